// File: rtl/apb_mac_cfg_slave.sv
// APB configuration slave for a MAC: MAC1/MAC2/FIR config registers plus
// a STATUS register (accepted write count, sticky protocol error, cfg_done).
// Ports:
//   pclk, presetn                  clock, async active-low reset
//   pselx, penable, pwrite, paddr, pwdata   APB request
//   prdata, pready, pslverr        APB response (pready only in ACCESS)
//   mac1_cfg, mac2_cfg, fir_cfg    register contents
//   cfg_update                     one-cycle pulse after each config write
//   cfg_done                       sticky: all three config regs written
// The FSM state trails the APB phase by one cycle: the master holds the
// access phase until it sees pready, and the write commits on that edge.
module apb_mac_cfg_slave #(
  parameter string SPEED_TYPE = "10/100/1000M_MAC"
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        pselx,
  input  logic        pwrite,
  input  logic        penable,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [7:0]  mac1_cfg,
  output logic [15:0] mac2_cfg,
  output logic [7:0]  fir_cfg,
  output logic        cfg_update,
  output logic        cfg_done
);

  localparam bit            SLOW_MAC    = (SPEED_TYPE == "10/100M_MAC");
  localparam logic [7:0]    ADDR_MAC1   = 8'h00;
  localparam logic [7:0]    ADDR_MAC2   = 8'h01;
  localparam logic [7:0]    ADDR_FIR    = 8'h12;
  localparam logic [7:0]    ADDR_STATUS = 8'h20;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] prdata_q, prdata_d;
  logic        slverr_q, slverr_d;
  logic [7:0]  mac1_q, mac1_d;
  logic [15:0] mac2_q, mac2_d;
  logic [7:0]  fir_q, fir_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        prot_q, prot_d;
  logic        upd_q, upd_d;
  logic        done_q, done_d;
  logic        w_mac1_q, w_mac1_d;
  logic        w_mac2_q, w_mac2_d;
  logic        w_fir_q, w_fir_d;

  logic        latch_c, go_access_c, commit_c, perr_c;
  logic        wr_c, cfg_wr_c, mapped_c;
  logic [31:0] rd_mux_c;
  logic        unused_c;

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state, protocol checking and commit decision
  always_comb begin
    state_d     = state_q;
    latch_c     = 1'b0;
    go_access_c = 1'b0;
    commit_c    = 1'b0;
    perr_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (penable) begin
          perr_c = 1'b1;
        end else if (pselx) begin
          state_d = SETUP;
          latch_c = 1'b1;
        end
      end
      SETUP: begin
        if (!pselx) begin
          perr_c  = 1'b1;
          state_d = IDLE;
        end else if (penable) begin
          state_d     = ACCESS;
          go_access_c = 1'b1;
        end
      end
      ACCESS: begin
        if (!pselx) begin
          state_d = IDLE;
        end else if (!penable) begin
          // master already started the next transfer
          state_d = SETUP;
          latch_c = 1'b1;
        end else if ((paddr != addr_q) || (pwrite != write_q)) begin
          perr_c  = 1'b1;
          state_d = IDLE;
        end else begin
          commit_c = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register file next values and response data
  always_comb begin
    addr_d  = latch_c ? paddr  : addr_q;
    write_d = latch_c ? pwrite : write_q;

    mapped_c = (addr_q == ADDR_MAC1) || (addr_q == ADDR_MAC2) ||
               (addr_q == ADDR_FIR)  || (addr_q == ADDR_STATUS);

    rd_mux_c = 32'h0;
    case (addr_q)
      ADDR_MAC1:   rd_mux_c = 32'(mac1_q);
      ADDR_MAC2:   rd_mux_c = 32'(mac2_q);
      ADDR_FIR:    rd_mux_c = 32'(fir_q);
      ADDR_STATUS: rd_mux_c = 32'({done_q, prot_q, cnt_q});
      default:     rd_mux_c = 32'h0;
    endcase

    prdata_d = (go_access_c && !write_q) ? rd_mux_c : 32'h0;
    slverr_d = go_access_c && !mapped_c;

    wr_c     = commit_c && write_q;
    cfg_wr_c = wr_c && ((addr_q == ADDR_MAC1) || (addr_q == ADDR_MAC2) ||
                        (addr_q == ADDR_FIR));

    mac1_d = mac1_q;
    mac2_d = mac2_q;
    fir_d  = fir_q;
    if (wr_c && (addr_q == ADDR_MAC1)) mac1_d = pwdata[7:0];
    if (wr_c && (addr_q == ADDR_MAC2)) begin
      mac2_d = pwdata[15:0];
      if (SLOW_MAC) mac2_d[9] = 1'b0;  // no gigabit mode on this variant
    end
    if (wr_c && (addr_q == ADDR_FIR)) fir_d = pwdata[7:0];

    w_mac1_d = w_mac1_q | (wr_c && (addr_q == ADDR_MAC1));
    w_mac2_d = w_mac2_q | (wr_c && (addr_q == ADDR_MAC2));
    w_fir_d  = w_fir_q  | (wr_c && (addr_q == ADDR_FIR));
    done_d   = done_q | (w_mac1_d & w_mac2_d & w_fir_d);

    cnt_d = (cfg_wr_c && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
    upd_d = cfg_wr_c;

    // new error wins over a simultaneous W1C clear
    prot_d = (prot_q & ~(wr_c && (addr_q == ADDR_STATUS) && pwdata[8])) | perr_c;
  end

  assign unused_c = ^pwdata[31:16];

  // Datapath registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      addr_q   <= 8'h0;
      write_q  <= 1'b0;
      prdata_q <= 32'h0;
      slverr_q <= 1'b0;
      mac1_q   <= 8'h0;
      mac2_q   <= 16'h0;
      fir_q    <= 8'h0;
      cnt_q    <= 8'h0;
      prot_q   <= 1'b0;
      upd_q    <= 1'b0;
      done_q   <= 1'b0;
      w_mac1_q <= 1'b0;
      w_mac2_q <= 1'b0;
      w_fir_q  <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      write_q  <= write_d;
      prdata_q <= prdata_d;
      slverr_q <= slverr_d;
      mac1_q   <= mac1_d;
      mac2_q   <= mac2_d;
      fir_q    <= fir_d;
      cnt_q    <= cnt_d;
      prot_q   <= prot_d;
      upd_q    <= upd_d;
      done_q   <= done_d;
      w_mac1_q <= w_mac1_d;
      w_mac2_q <= w_mac2_d;
      w_fir_q  <= w_fir_d;
    end
  end

  assign prdata     = prdata_q;
  assign pready     = (state_q == ACCESS);
  assign pslverr    = slverr_q;
  assign mac1_cfg   = mac1_q;
  assign mac2_cfg   = mac2_q;
  assign fir_cfg    = fir_q;
  assign cfg_update = upd_q;
  assign cfg_done   = done_q;

endmodule

// File: tb/tb_apb_mac_cfg_slave.sv
// Directed bench for apb_mac_cfg_slave: table of APB transfers with
// hand-computed responses, plus sequences for protocol errors, reset
// during ACCESS, the 10/100M variant and write-count saturation.
module tb_apb_mac_cfg_slave;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        pselx, pwrite, penable;
  logic [7:0]  paddr;
  logic [31:0] pwdata;

  logic [31:0] prdata, prdata_b;
  logic        pready, pready_b, pslverr, pslverr_b;
  logic [7:0]  mac1_cfg, mac1_b, fir_cfg, fir_b;
  logic [15:0] mac2_cfg, mac2_b;
  logic        cfg_update, upd_b, cfg_done, done_b;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_mac_cfg_slave dut (
    .pclk(pclk), .presetn(presetn), .pselx(pselx), .pwrite(pwrite),
    .penable(penable), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .mac1_cfg(mac1_cfg),
    .mac2_cfg(mac2_cfg), .fir_cfg(fir_cfg), .cfg_update(cfg_update),
    .cfg_done(cfg_done)
  );

  apb_mac_cfg_slave #(.SPEED_TYPE("10/100M_MAC")) dut_slow (
    .pclk(pclk), .presetn(presetn), .pselx(pselx), .pwrite(pwrite),
    .penable(penable), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b),
    .pready(pready_b), .pslverr(pslverr_b), .mac1_cfg(mac1_b),
    .mac2_cfg(mac2_b), .fir_cfg(fir_b), .cfg_update(upd_b),
    .cfg_done(done_b)
  );

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
    bit          exp_upd;
    bit          exp_done;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One APB transfer: setup, access held until pready, then idle.
  task automatic apb_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic [31:0] rd2,
                          output logic err, output logic upd);
    bit ok;
    @(posedge pclk); #1;
    pselx = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge pclk);
      if (pready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("pready_timeout", 32'(ok), 32'd1);
    rd = prdata; rd2 = prdata_b; err = pslverr;
    @(posedge pclk); #1;
    pselx = 1'b0; penable = 1'b0;
    @(negedge pclk);
    upd = cfg_update;
  endtask

  logic [31:0] rd, rd2;
  logic        err, upd;

  initial begin
    vecs[0]  = '{1'b1, 8'h00, 32'h0000_0035, 32'h0,   1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 32'h0,         32'h35,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h01, 32'hFFFF_7211, 32'h0,   1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h01, 32'h0,         32'h7211,1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h12, 32'h0000_0180, 32'h0,   1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 8'h12, 32'h0,         32'h80,  1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 8'h20, 32'h0,         32'h203, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 8'h05, 32'h0000_00AA, 32'h0,   1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 8'h05, 32'h0,         32'h0,   1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 8'h20, 32'h0000_0000, 32'h0,   1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'h20, 32'h0,         32'h203, 1'b0, 1'b0, 1'b1};

    presetn = 1'b0; pselx = 1'b0; pwrite = 1'b0; penable = 1'b0;
    paddr = 8'h0; pwdata = 32'h0;
    #12;
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pready", 32'(pready), 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    chk("rst_cfg", {mac1_cfg, mac2_cfg, fir_cfg}, 32'h0);
    chk("rst_upd_done", {30'h0, cfg_update, cfg_done}, 32'h0);
    @(negedge pclk); presetn = 1'b1;

    // Register map, errors and STATUS behaviour
    for (int i = 0; i < 11; i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, rd2, err, upd);
      $display("vector %0d addr 0x%0h wr %0d", i, vecs[i].addr, vecs[i].wr);
      chk("vec_pslverr", 32'(err), 32'(vecs[i].exp_err));
      chk("vec_cfg_update", 32'(upd), 32'(vecs[i].exp_upd));
      chk("vec_cfg_done", 32'(cfg_done), 32'(vecs[i].exp_done));
      if (!vecs[i].wr) chk("vec_prdata", rd, vecs[i].exp_rd);
    end
    chk("mac1_cfg", 32'(mac1_cfg), 32'h35);
    chk("mac2_cfg", 32'(mac2_cfg), 32'h7211);
    chk("fir_cfg", 32'(fir_cfg), 32'h80);
    @(negedge pclk);
    chk("upd_one_cycle", 32'(cfg_update), 32'h0);

    // 10/100M variant forces mac2 bit 9 low
    apb_xfer(1'b1, 8'h01, 32'h7311, rd, rd2, err, upd);
    chk("fast_mac2", 32'(mac2_cfg), 32'h7311);
    chk("slow_mac2", 32'(mac2_b), 32'h7111);
    apb_xfer(1'b0, 8'h01, 32'h0, rd, rd2, err, upd);
    chk("fast_mac2_rd", rd, 32'h7311);
    chk("slow_mac2_rd", rd2, 32'h0000_7111);

    // penable asserted straight from IDLE
    @(posedge pclk); #1;
    pselx = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h99;
    @(posedge pclk); #1;
    pselx = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk("perr_idle_upd", 32'(cfg_update), 32'h0);
    chk("perr_idle_mac1", 32'(mac1_cfg), 32'h35);
    apb_xfer(1'b0, 8'h20, 32'h0, rd, rd2, err, upd);
    chk("perr_idle_status", rd, 32'h304);
    apb_xfer(1'b1, 8'h20, 32'h100, rd, rd2, err, upd);
    chk("w1c_err", 32'(err), 32'h0);
    chk("w1c_upd", 32'(upd), 32'h0);
    apb_xfer(1'b0, 8'h20, 32'h0, rd, rd2, err, upd);
    chk("w1c_status", rd, 32'h204);

    // pselx dropped during SETUP
    @(posedge pclk); #1;
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h66;
    @(posedge pclk); #1;
    pselx = 1'b0;
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("perr_setup_upd", 32'(cfg_update), 32'h0);
    chk("perr_setup_mac1", 32'(mac1_cfg), 32'h35);
    apb_xfer(1'b0, 8'h20, 32'h0, rd, rd2, err, upd);
    chk("perr_setup_status", rd, 32'h304);

    // reset asserted during ACCESS of a write
    @(posedge pclk); #1;
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h55;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    chk("mid_rst_in_access", 32'(pready), 32'h1);
    #1 presetn = 1'b0;
    #1;
    chk("mid_rst_pready", 32'(pready), 32'h0);
    chk("mid_rst_resp", {prdata[30:0], pslverr}, 32'h0);
    chk("mid_rst_cfg", {mac1_cfg, mac2_cfg, fir_cfg}, 32'h0);
    chk("mid_rst_upd_done", {30'h0, cfg_update, cfg_done}, 32'h0);
    @(posedge pclk); #1;
    pselx = 1'b0; penable = 1'b0;
    @(negedge pclk); presetn = 1'b1;
    @(negedge pclk);
    chk("post_rst_mac1", 32'(mac1_cfg), 32'h0);
    chk("post_rst_upd", 32'(cfg_update), 32'h0);

    // 260 config writes saturate the count
    for (int i = 0; i < 260; i++) begin
      apb_xfer(1'b1, 8'h00, 32'(i), rd, rd2, err, upd);
      chk("sat_upd", 32'(upd), 32'h1);
    end
    chk("sat_mac1", 32'(mac1_cfg), 32'h03);
    apb_xfer(1'b0, 8'h20, 32'h0, rd, rd2, err, upd);
    chk("sat_status", rd, 32'h0FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
